// File: rtl/nibble_add_pkg.sv
// Shared types and helpers for the nibble-serial add controller.
package nibble_add_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        RESP
    } state_e;

    // Index width for a nibble counter; a single-nibble datapath still needs one bit.
    function automatic int unsigned idx_width(input int unsigned nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/four_bit_adder.sv
// Combinational 4-bit ripple adder slice shared by the nibble controller.
module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);

endmodule

// File: rtl/nibble_add_ctrl.sv
// Two-requester, round-robin controller that performs WIDTH-bit additions one
// nibble per cycle through a shared four_bit_adder, LSB nibble first.
module nibble_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id,
    output logic             busy
);

    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_e             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               id_q, id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q;

    logic               grant0, grant1;
    logic [NIB_W-1:0]   add_a, add_b, add_sum;
    logic               add_cout;

    // ptr_q == 0 favours req0 when both requesters are valid.
    assign grant0 = req0_valid && (!req1_valid || !ptr_q);
    assign grant1 = req1_valid && (!req0_valid || ptr_q);

    assign req0_ready = rst_n && (state_q == IDLE) && grant0;
    assign req1_ready = rst_n && (state_q == IDLE) && grant1;

    assign add_a = a_q[idx_q*NIB_W +: NIB_W];
    assign add_b = b_q[idx_q*NIB_W +: NIB_W];

    four_bit_adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            IDLE: begin
                if (req0_ready) begin
                    a_d     = req0_a;
                    b_d     = req0_b;
                    carry_d = req0_cin;
                    id_d    = 1'b0;
                    ptr_d   = 1'b1;
                    idx_d   = '0;
                    state_d = ADD;
                end else if (req1_ready) begin
                    a_d     = req1_a;
                    b_d     = req1_b;
                    carry_d = req1_cin;
                    id_d    = 1'b1;
                    ptr_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[idx_q*NIB_W +: NIB_W] = add_sum;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d      = add_cout;
                    rsp_valid_d = 1'b1;
                    idx_d       = '0;
                    state_d     = RESP;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_id    = id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_add_ctrl.sv
// Scoreboard bench for nibble_add_ctrl: drivers push expected responses at accept,
// a negedge monitor pops and compares whenever a response is presented.
module tb_nibble_add_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_cin = 1'b0, req1_cin = 1'b0;
    logic         rsp_valid, rsp_cout, rsp_id, busy;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_sum;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct packed {
        logic         id;
        logic         cout;
        logic [W-1:0] sum;
        logic [31:0]  acc;
    } exp_t;

    exp_t exp_q[$];

    nibble_add_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic id, input logic [W-1:0] s, input logic co, input int acc);
        exp_t e;
        e.id   = id;
        e.cout = co;
        e.sum  = s;
        e.acc  = acc;
        exp_q.push_back(e);
    endtask

    // Monitor: compares the presented response against the queue head.
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            chk("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("no_unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
            end else if (rsp_valid) begin
                e = exp_q[0];
                if (!prev_v) chk("latency", cyc - e.acc, 32'd4);
                chk("rsp_sum", {16'd0, rsp_sum}, {16'd0, e.sum});
                chk("rsp_cout", {31'd0, rsp_cout}, {31'd0, e.cout});
                chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                if (!rsp_ready) chk("ready_in_resp", {30'd0, req0_ready, req1_ready}, 32'd0);
                else void'(exp_q.pop_front());
            end
            prev_v = rsp_valid;
        end
    end

    task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic [W-1:0] es, input logic ec);
        int acc;
        acc = -1;
        @(posedge clk); #1;
        if (id == 1'b0) begin
            req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((id == 1'b0) ? req0_ready : req1_ready) begin
                acc = cyc + 1;
                push(id, es, ec, acc);
                break;
            end
        end
        if (acc < 0) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int acc[4];
        int who[4];
        int n;
        int hs;
        int a2;
        bit seen;

        // Reset: everything low even with valids asserted.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #12;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_sum", {16'd0, rsp_sum}, 32'd0);
        chk("rst_rsp_cout", {31'd0, rsp_cout}, 32'd0);
        chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_ready", {30'd0, req0_ready, req1_ready}, 32'd0);

        // Basic and carry-ripple operations.
        issue(1'b0, 16'h1234, 16'h0F0F, 1'b0, 16'h2143, 1'b0);
        issue(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        drain();

        // Contention: both valid continuously, pointer favours req0 here.
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b0;
        req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 80 && n < 4; i++) begin
            @(negedge clk);
            if (req0_ready) begin
                acc[n] = cyc + 1; who[n] = 0; n++;
                push(1'b0, 16'h0003, 1'b0, cyc + 1);
            end else if (req1_ready) begin
                acc[n] = cyc + 1; who[n] = 1; n++;
                push(1'b1, 16'h0001, 1'b1, cyc + 1);
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("contend_count", n, 32'd4);
        for (int i = 0; i < n; i++) chk("grant_order", who[i], i % 2);
        for (int i = 1; i < n; i++) chk("accept_spacing", acc[i] - acc[i-1], 32'd6);
        drain();

        issue(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        drain();

        // Backpressure: hold the response 5 cycles while req0 waits.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        issue(1'b1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
        req0_a = 16'h0010; req0_b = 16'h0020; req0_cin = 1'b0;
        req0_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_rsp_seen", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        hs = cyc + 1;
        a2 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_ready) begin
                a2 = cyc + 1;
                push(1'b0, 16'h0030, 1'b0, a2);
                break;
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        chk("bp_accept_after_hs", a2 - hs, 32'd1);
        drain();

        // Mid-operation reset: two ADD edges, then reset discards the operation.
        issue(1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // After reset the pointer favours req0.
        @(posedge clk); #1;
        req0_a = 16'h0A0A; req0_b = 16'h0505; req0_cin = 1'b1;
        req1_a = 16'h0000; req1_b = 16'h0000; req1_cin = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        chk("prio_req0", {31'd0, req0_ready}, 32'd1);
        chk("prio_req1", {31'd0, req1_ready}, 32'd0);
        if (req0_ready) push(1'b0, 16'h0F10, 1'b0, cyc + 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
